chunked_magnitude_comparator: RTL and testbench
===============================================

Name: chunked_magnitude_comparator

Overview:
- Multi-cycle magnitude comparator for WIDTH-bit operands, with signed/unsigned mode selected per operation.
- Compares CHUNK bits per cycle, most-significant chunk first, and terminates as soon as a chunk differs.
- Result is one-hot less/equal/greater flags plus the number of compare cycles used.
- Valid/ready handshake on both the operand and result sides.
- Replaces fixed-width single-cycle comparators where wide operands would otherwise create long carry/compare paths.

Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 4, bits compared per cycle. WIDTH must be a multiple of CHUNK; otherwise elaboration error.
- (derived) N = WIDTH/CHUNK, the number of chunks.
- (derived) CW = clog2(N+1), the width of the cycles output.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  operands presented.
- start_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- l  out  1  A < B.
- e  out  1  A == B.
- g  out  1  A > B.
- cycles  out  CW  compare cycles used, 1..N.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; res_valid = 0; l = e = g = 0; cycles = 0; internal operand registers cleared.
  - start_ready = 1 once state is IDLE.
  - Reset mid-operation abandons the compare; no result is produced.
- start_ready = (state == IDLE), combinational from state.
- States:
  - IDLE:
    - On start_valid & start_ready, register a, b, signed_mode; set chunk index to N-1 (top chunk); clear cycle counter; go to COMPARE.
    - a, b and signed_mode are ignored at all other times.
  - COMPARE:
    - Each cycle, compare chunk[idx] of the registered A and B as unsigned CHUNK-bit values, then increment the cycle counter.
    - Signed mode: for the top chunk only (idx = N-1), invert the MSB of both operands before comparing (offset-binary). Lower chunks are always compared unsigned.
    - Chunks differ: set g = (A chunk > B chunk), l = !g, e = 0; go to DONE.
    - Chunks equal and idx > 0: decrement idx; stay in COMPARE.
    - Chunks equal and idx == 0: set e = 1, l = g = 0; go to DONE.
    - cycles = k, where k is the position of the first differing chunk counted from the top (1..N); k = N when the operands are equal.
  - DONE:
    - res_valid = 1; l, e, g and cycles held stable.
    - On res_ready: res_valid = 0, l = e = g = 0 on the next edge, state goes to IDLE. cycles keeps its last value.
- Latency: operand accept edge to res_valid high is k cycles, with res_valid rising at the edge that ends the k-th COMPARE cycle. Minimum 1 (top chunk differs); maximum N (equal, or operands differ only in chunk 0).
- Throughput: after the result handshake there is one IDLE cycle before the next accept. Back-to-back throughput is k+2 cycles per operation when res_ready is held high.
- Flag invariants:
  - Exactly one of l, e, g is high whenever res_valid = 1.
  - All three are 0 whenever res_valid = 0.
- Boundary conditions:
  - CHUNK == WIDTH: N = 1, always 1-cycle latency, cycles = 1.
  - start_valid asserted while in COMPARE or DONE is not accepted (start_ready = 0). The source must hold its operands until accepted.
  - res_ready may be high before DONE is reached; the handshake completes in the first DONE cycle.
  - In signed mode with both operands at the most-negative value (e.g. 0x8000_0000), the result is e = 1 after N cycles.

Test Plan:
All scenarios use WIDTH = 32, CHUNK = 4 (N = 8), res_ready held high unless stated.
- Unsigned, a=0x8000_0000, b=0x7FFF_FFFF -> g=1, l=e=0, cycles=1; res_valid rises 1 cycle after accept.
- a=b=0x1234_5678, signed_mode=0 -> e=1, cycles=8; repeat with signed_mode=1 -> same result.
- a=0xFFFF_FFFF, b=0x0000_0001: signed -> l=1, cycles=1; unsigned -> g=1, cycles=1. Also a=0x8000_0000, b=0x7FFF_FFFF signed -> l=1.
- a=0xABCD_EF00, b=0xABCD_EF01, unsigned -> l=1, cycles=8.
- Backpressure:
  - Hold res_ready=0 for 5 cycles in DONE -> res_valid, flags and cycles remain stable; start_ready=0 and a concurrent start_valid is not accepted.
  - Raise res_ready -> IDLE on the next cycle; the next operand pair is accepted.
- Assert rst_n low mid-COMPARE (a=0, b=1, 3rd cycle) -> res_valid=0, l=e=g=0, cycles=0 immediately, start_ready=1 after reset release. A new compare then completes correctly.

Source files
------------

// File: rtl/chunked_magnitude_comparator_if.sv
// Operand/result handshake bundle for the chunked magnitude comparator.
// The master side presents operands and accepts results; the slave side is
// the comparator itself.
interface chunked_magnitude_comparator_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 4
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             res_valid;
  logic             res_ready;
  logic             l;
  logic             e;
  logic             g;
  logic [CW-1:0]    cycles;

  modport master (
    output start_valid, a, b, signed_mode, res_ready,
    input  start_ready, res_valid, l, e, g, cycles
  );

  modport slave (
    input  start_valid, a, b, signed_mode, res_ready,
    output start_ready, res_valid, l, e, g, cycles
  );
endinterface

// File: rtl/chunked_magnitude_comparator.sv
// Multi-cycle magnitude comparator. Walks the operands CHUNK bits at a time
// from the most-significant chunk down and stops at the first chunk that
// differs, producing one-hot less/equal/greater flags and the number of
// compare cycles spent. Signed compares are handled by flipping the sign bit
// of the top chunk only (offset-binary), so every chunk compare is unsigned.
module chunked_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic clk,
  input  logic rst_n,
  chunked_magnitude_comparator_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
      $error("chunked_magnitude_comparator: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             smode_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             res_valid_q;
  logic             l_q;
  logic             e_q;
  logic             g_q;

  logic             flip_msb;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;

  // Pull chunk i out of v; optionally invert its MSB to map two's complement
  // onto an order-preserving unsigned code.
  function automatic logic [CHUNK-1:0] get_chunk(
    input logic [WIDTH-1:0] v,
    input logic [IW-1:0]    i,
    input logic             flip
  );
    logic [CHUNK-1:0] c;
    c = CHUNK'(v >> (int'(i) * CHUNK));
    if (flip) begin
      c[CHUNK-1] = ~c[CHUNK-1];
    end
    return c;
  endfunction

  // Select the current chunk pair; sign handling only applies to the top chunk.
  always_comb begin
    flip_msb = smode_q && (idx == IW'(N - 1));
    chunk_a  = get_chunk(a_q, idx, flip_msb);
    chunk_b  = get_chunk(b_q, idx, flip_msb);
  end

  // Control FSM with registered result flags, cycle counter and operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      smode_q     <= 1'b0;
      idx         <= '0;
      cnt         <= '0;
      res_valid_q <= 1'b0;
      l_q         <= 1'b0;
      e_q         <= 1'b0;
      g_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            smode_q <= bus.signed_mode;
            idx     <= IW'(N - 1);
            cnt     <= '0;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          cnt <= cnt + CW'(1);
          if (chunk_a != chunk_b) begin
            g_q         <= (chunk_a > chunk_b);
            l_q         <= !(chunk_a > chunk_b);
            e_q         <= 1'b0;
            res_valid_q <= 1'b1;
            state       <= DONE;
          end else if (idx != '0) begin
            idx <= idx - IW'(1);
          end else begin
            g_q         <= 1'b0;
            l_q         <= 1'b0;
            e_q         <= 1'b1;
            res_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            l_q         <= 1'b0;
            e_q         <= 1'b0;
            g_q         <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.res_valid   = res_valid_q;
  assign bus.l           = l_q;
  assign bus.e           = e_q;
  assign bus.g           = g_q;
  assign bus.cycles      = cnt;

endmodule

// File: tb/tb_chunked_magnitude_comparator.sv
// Directed bench for chunked_magnitude_comparator (WIDTH=32, CHUNK=4, N=8).
module tb_chunked_magnitude_comparator;

  localparam int WIDTH = 32;
  localparam int CHUNK = 4;
  localparam int CW    = 4;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_bad;

  chunked_magnitude_comparator_if #(.WIDTH(WIDTH), .CW(CW)) ifc ();

  chunked_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic        l;
    logic        e;
    logic        g;
    int          cyc;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands and hold them until the comparator takes them.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sm);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    ifc.a           = a;
    ifc.b           = b;
    ifc.signed_mode = sm;
    ifc.start_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ifc.start_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    ifc.start_valid = 1'b0;
  endtask

  // Count edges from accept until res_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ifc.res_valid) break;
    end
    chk("res_valid_timeout", {31'd0, ifc.res_valid}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int lat;
    launch(v.a, v.b, v.sm);
    wait_result(lat);
    chk($sformatf("v%0d_l", id), {31'd0, ifc.l}, {31'd0, v.l});
    chk($sformatf("v%0d_e", id), {31'd0, ifc.e}, {31'd0, v.e});
    chk($sformatf("v%0d_g", id), {31'd0, ifc.g}, {31'd0, v.g});
    chk($sformatf("v%0d_cycles", id), {28'd0, ifc.cycles}, v.cyc);
    chk($sformatf("v%0d_latency", id), lat, v.cyc);
    chk($sformatf("v%0d_start_ready_busy", id), {31'd0, ifc.start_ready}, 32'd0);
    if (ifc.res_ready) begin
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid_drop", id), {31'd0, ifc.res_valid}, 32'd0);
      chk($sformatf("v%0d_flags_clear", id), {29'd0, ifc.l, ifc.e, ifc.g}, 32'd0);
      chk($sformatf("v%0d_cycles_kept", id), {28'd0, ifc.cycles}, v.cyc);
      chk($sformatf("v%0d_idle_ready", id), {31'd0, ifc.start_ready}, 32'd1);
    end
  endtask

  initial begin
    vec_t v;
    int   lat;
    n_vec = 0;
    n_bad = 0;

    //          a             b             sm    l     e     g     cyc
    vecs[0]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[1]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0, 8};
    vecs[2]  = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b0, 8};
    vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[5]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[6]  = '{32'hABCD_EF00, 32'hABCD_EF01, 1'b0, 1'b1, 1'b0, 1'b0, 8};
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 8};
    vecs[8]  = '{32'h1234_5678, 32'h1234_5878, 1'b0, 1'b1, 1'b0, 1'b0, 6};
    vecs[9]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 8};
    vecs[11] = '{32'h0000_0010, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 7};

    ifc.start_valid = 1'b0;
    ifc.a           = '0;
    ifc.b           = '0;
    ifc.signed_mode = 1'b0;
    ifc.res_ready   = 1'b1;
    rst_n           = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", {31'd0, ifc.res_valid}, 32'd0);
    chk("rst_flags", {29'd0, ifc.l, ifc.e, ifc.g}, 32'd0);
    chk("rst_cycles", {28'd0, ifc.cycles}, 32'd0);
    chk("rst_start_ready", {31'd0, ifc.start_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], i);
    end

    // Backpressure: result held while res_ready is low; new start refused.
    ifc.res_ready = 1'b0;
    launch(32'h3000_0000, 32'h1000_0000, 1'b0);
    wait_result(lat);
    chk("bp_latency", lat, 1);
    ifc.a           = 32'h0000_0001;
    ifc.b           = 32'h0000_0002;
    ifc.signed_mode = 1'b0;
    ifc.start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_res_valid", i), {31'd0, ifc.res_valid}, 32'd1);
      chk($sformatf("bp%0d_flags", i), {29'd0, ifc.l, ifc.e, ifc.g}, 32'd1);
      chk($sformatf("bp%0d_cycles", i), {28'd0, ifc.cycles}, 32'd1);
      chk($sformatf("bp%0d_start_ready", i), {31'd0, ifc.start_ready}, 32'd0);
    end
    ifc.start_valid = 1'b0;
    ifc.res_ready   = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {31'd0, ifc.res_valid}, 32'd0);
    chk("bp_release_flags", {29'd0, ifc.l, ifc.e, ifc.g}, 32'd0);
    chk("bp_release_ready", {31'd0, ifc.start_ready}, 32'd1);
    v = '{32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 1'b0, 1'b0, 8};
    run_vec(v, 100);

    // Reset in the third compare cycle abandons the operation.
    launch(32'h0000_0000, 32'h0000_0001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", {31'd0, ifc.res_valid}, 32'd0);
    chk("midrst_flags", {29'd0, ifc.l, ifc.e, ifc.g}, 32'd0);
    chk("midrst_cycles", {28'd0, ifc.cycles}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_start_ready", {31'd0, ifc.start_ready}, 32'd1);
    chk("midrst_no_result", {31'd0, ifc.res_valid}, 32'd0);
    v = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b0, 8};
    run_vec(v, 101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Flag invariants checked continuously away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.res_valid && ({2'b00, ifc.l} + {2'b00, ifc.e} + {2'b00, ifc.g}) != 3'd1) begin
        n_bad++;
        $display("FAIL onehot: flags %b%b%b, expected exactly one set", ifc.l, ifc.e, ifc.g);
      end
      if (!ifc.res_valid && (ifc.l || ifc.e || ifc.g)) begin
        n_bad++;
        $display("FAIL idle_flags: flags %b%b%b, expected 000", ifc.l, ifc.e, ifc.g);
      end
    end
  end

  // Absolute time guard.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
